// File: rtl/rggen_apb_bridge.sv
// Host-side rggen request/response channel to APB4 master bridge.
// One transfer in flight: IDLE -> SETUP -> ACCESS (wait states / timeout) -> RESPONSE.
module rggen_apb_bridge #(
  parameter int          ADDRESS_WIDTH  = 8,
  parameter int          BUS_WIDTH      = 32,
  parameter int          TIMEOUT_CYCLES = 0,
  parameter logic [2:0]  PPROT_VALUE    = 3'b000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_write,
  input  logic [BUS_WIDTH-1:0]     i_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_strobe,
  output logic [BUS_WIDTH-1:0]     o_read_data,
  output logic [1:0]               o_status,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic                     o_pwrite,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr
);

  localparam int STRB_W   = BUS_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {ADDRESS_WIDTH{1'b1}} << ADDR_LSB;
  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    ACCESS   = 2'd2,
    RESPONSE = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic accept;
  logic access_done;
  logic timeout_hit;
  logic timed_out;

  logic [ADDRESS_WIDTH-1:0] paddr_p0;
  logic                     pwrite_p0;
  logic [BUS_WIDTH-1:0]     pwdata_p0;
  logic [STRB_W-1:0]        pstrb_p0;
  logic [BUS_WIDTH-1:0]     read_data_p1;
  logic [1:0]               status_p1;

  function automatic logic [ADDRESS_WIDTH-1:0] align_address(input logic [ADDRESS_WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  function automatic logic [1:0] slave_status(input logic slverr);
    return slverr ? STATUS_SLVERR : STATUS_OKAY;
  endfunction

  assign accept      = (state == IDLE) && i_valid;
  assign access_done = (state == ACCESS) && i_pready;
  assign timed_out   = (state == ACCESS) && !i_pready && timeout_hit;

  // ACCESS wait counter: cleared outside ACCESS, so it restarts on every entry
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wait_count <= '0;
      end else if (state != ACCESS) begin
        wait_count <= '0;
      end else if (!i_pready) begin
        wait_count <= wait_count + CNT_W'(1);
      end
    end

    assign timeout_hit = (wait_count == LAST_WAIT);
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = SETUP;
      SETUP:    next_state = ACCESS;
      ACCESS:   if (access_done || timed_out) next_state = RESPONSE;
      RESPONSE: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    o_psel    = 1'b0;
    o_penable = 1'b0;
    o_ready   = 1'b0;
    case (state)
      SETUP:    o_psel = 1'b1;
      ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
      end
      RESPONSE: o_ready = 1'b1;
      default:  ;
    endcase
  end

  // Request capture stage: held stable from SETUP through ACCESS
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      paddr_p0  <= '0;
      pwrite_p0 <= 1'b0;
      pwdata_p0 <= '0;
      pstrb_p0  <= '0;
    end else if (accept) begin
      paddr_p0  <= align_address(i_address);
      pwrite_p0 <= i_write;
      pwdata_p0 <= i_write ? i_write_data : '0;
      pstrb_p0  <= i_write ? i_strobe : '0;
    end
  end

  // Response capture stage: holds until the next completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      read_data_p1 <= '0;
      status_p1    <= STATUS_OKAY;
    end else if (access_done) begin
      read_data_p1 <= pwrite_p0 ? '0 : i_prdata;
      status_p1    <= slave_status(i_pslverr);
    end else if (timed_out) begin
      read_data_p1 <= '0;
      status_p1    <= STATUS_SLVERR;
    end
  end

  assign o_paddr     = paddr_p0;
  assign o_pwrite    = pwrite_p0;
  assign o_pwdata    = pwdata_p0;
  assign o_pstrb     = pstrb_p0;
  assign o_pprot     = PPROT_VALUE;
  assign o_read_data = read_data_p1;
  assign o_status    = status_p1;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Randomized bench for rggen_apb_bridge: transaction-level model predicts every
// output each cycle from the transfer plan (wait states, timeout, reset abort).
module tb_rggen_apb_bridge;

  localparam int         AW = 8;
  localparam int         BW = 32;
  localparam int         SW = 4;
  localparam int         TO = 4;
  localparam logic [2:0] PP = 3'b101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [AW-1:0] address;
  logic          write;
  logic [BW-1:0] write_data;
  logic [SW-1:0] strobe;
  logic [BW-1:0] read_data;
  logic [1:0]    status;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic [BW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic [BW-1:0] prdata;
  logic          pslverr;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO), .PPROT_VALUE(PP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_address(address), .i_write(write), .i_write_data(write_data), .i_strobe(strobe),
    .o_read_data(read_data), .o_status(status),
    .o_psel(psel), .o_penable(penable), .o_paddr(paddr), .o_pprot(pprot),
    .o_pwrite(pwrite), .o_pwdata(pwdata), .o_pstrb(pstrb),
    .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: expected outputs for the current cycle
  logic          chk_en = 1'b0;
  logic          exp_psel, exp_penable, exp_ready, exp_pwrite;
  logic [AW-1:0] exp_paddr;
  logic [BW-1:0] exp_pwdata, exp_rdata;
  logic [SW-1:0] exp_pstrb;
  logic [1:0]    exp_status;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_psel = 1'b0; exp_penable = 1'b0; exp_ready = 1'b0; exp_pwrite = 1'b0;
    exp_paddr = '0; exp_pwdata = '0; exp_pstrb = '0; exp_rdata = '0; exp_status = 2'b00;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("psel",      64'(psel),      64'(exp_psel));
      check("penable",   64'(penable),   64'(exp_penable));
      check("ready",     64'(ready),     64'(exp_ready));
      check("paddr",     64'(paddr),     64'(exp_paddr));
      check("pwrite",    64'(pwrite),    64'(exp_pwrite));
      check("pwdata",    64'(pwdata),    64'(exp_pwdata));
      check("pstrb",     64'(pstrb),     64'(exp_pstrb));
      check("pprot",     64'(pprot),     64'(PP));
      check("read_data", 64'(read_data), 64'(exp_rdata));
      check("status",    64'(status),    64'(exp_status));
    end
  end

  task automatic scramble_host();
    valid      = 1'($urandom_range(0, 1));
    address    = AW'($urandom);
    write      = 1'($urandom_range(0, 1));
    write_data = $urandom;
    strobe     = SW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      scramble_host();
      valid   = 1'b0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
      exp_psel = 1'b0; exp_penable = 1'b0; exp_ready = 1'b0;
    end
  endtask

  // waits >= TO means the slave never answers; abort_at >= 0 resets in that ACCESS cycle
  task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wd,
                         input logic [SW-1:0] st, input int waits, input logic [BW-1:0] rd,
                         input logic err, input int abort_at);
    bit tmo;
    int n_acc;
    tmo   = (waits >= TO);
    n_acc = tmo ? TO : waits + 1;
    // request presented in an IDLE cycle
    @(posedge clk); #1;
    valid = 1'b1; address = addr; write = wr; write_data = wd; strobe = st;
    pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    exp_psel = 1'b0; exp_penable = 1'b0; exp_ready = 1'b0;
    // SETUP
    @(posedge clk); #1;
    scramble_host();
    pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    exp_psel = 1'b1; exp_penable = 1'b0;
    exp_paddr  = addr & 8'hFC;
    exp_pwrite = wr;
    exp_pwdata = wr ? wd : '0;
    exp_pstrb  = wr ? st : '0;
    // ACCESS
    for (int j = 0; j < n_acc; j++) begin
      @(posedge clk); #1;
      scramble_host();
      exp_psel = 1'b1; exp_penable = 1'b1;
      if (!tmo && j == waits) begin
        pready = 1'b1; prdata = rd; pslverr = err;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
      end
      if (j == abort_at) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_psel",    64'(psel),    64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_ready",   64'(ready),   64'd0);
        check("rst_paddr",   64'(paddr),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0; pready = 1'b0;
        return;
      end
    end
    // RESPONSE: a request offered here must wait for the next IDLE
    @(posedge clk); #1;
    scramble_host();
    valid = 1'b1;
    pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
    exp_psel = 1'b0; exp_penable = 1'b0; exp_ready = 1'b1;
    exp_rdata  = (tmo || wr) ? '0 : rd;
    exp_status = (tmo || err) ? 2'b10 : 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0; address = '0; write = 1'b0; write_data = '0; strobe = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // zero-wait read
    run_txn(8'h14, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, -1);
    @(negedge clk);
    check("lit_rd_data",   64'(read_data), 64'hDEADBEEF);
    check("lit_rd_status", 64'(status),    64'd0);
    check("lit_rd_pstrb",  64'(pstrb),     64'd0);
    idle(1);

    // write with 3 wait states
    run_txn(8'h08, 1'b1, 32'h12345678, 4'b0101, 3, 32'hFFFFFFFF, 1'b0, -1);
    @(negedge clk);
    check("lit_wr_pwdata", 64'(pwdata),    64'h12345678);
    check("lit_wr_pstrb",  64'(pstrb),     64'h5);
    check("lit_wr_rdata",  64'(read_data), 64'd0);
    check("lit_wr_status", 64'(status),    64'd0);
    idle(1);

    // slave error read
    run_txn(8'h20, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE0001, 1'b1, -1);
    @(negedge clk);
    check("lit_err_status", 64'(status),    64'h2);
    check("lit_err_rdata",  64'(read_data), 64'hCAFE0001);
    idle(1);

    // timeout, then pready on the last permitted ACCESS cycle
    run_txn(8'h30, 1'b0, 32'h0, 4'h0, 4, 32'h11111111, 1'b0, -1);
    @(negedge clk);
    check("lit_to_status", 64'(status),    64'h2);
    check("lit_to_rdata",  64'(read_data), 64'd0);
    idle(1);
    run_txn(8'h30, 1'b0, 32'h0, 4'h0, 3, 32'h0BADF00D, 1'b0, -1);
    @(negedge clk);
    check("lit_edge_status", 64'(status),    64'd0);
    check("lit_edge_rdata",  64'(read_data), 64'h0BADF00D);
    idle(1);

    // unaligned address
    run_txn(8'h17, 1'b1, 32'hA5A5A5A5, 4'b1111, 0, 32'h0, 1'b0, -1);
    @(negedge clk);
    check("lit_unaligned_paddr", 64'(paddr), 64'h14);
    idle(1);

    // reset mid-ACCESS, then a zero-wait read completes normally
    run_txn(8'h44, 1'b1, 32'h55AA55AA, 4'b0011, 3, 32'h0, 1'b0, 1);
    run_txn(8'h48, 1'b0, 32'h0, 4'h0, 0, 32'h600DCAFE, 1'b0, -1);
    @(negedge clk);
    check("lit_post_rst_rdata", 64'(read_data), 64'h600DCAFE);
    idle(1);

    // back-to-back and randomized transfers
    for (int k = 0; k < 60; k++) begin
      run_txn(AW'($urandom), 1'($urandom_range(0, 1)), $urandom, SW'($urandom),
              int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1)), -1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rggen_apb_bridge.md
Name: rggen_apb_bridge

Overview:
- Bus-to-APB master bridge: takes one request at a time from a host-side rggen bus request/response channel and runs it as an APB4 SETUP/ACCESS transfer.
- Sits directly upstream of an APB register block slave adapter, or of an APB fabric feeding one.
- Captures the request, drives the APB master signals, and returns read data and rggen status to the host.
- Optional ACCESS-phase timeout turns a hung slave into an error response.

Parameters:
- ADDRESS_WIDTH, 8, width of host address and paddr.
- BUS_WIDTH, 32, data width; must be 8, 16, 32 or 64.
- TIMEOUT_CYCLES, 0, max ACCESS cycles waiting for pready; 0 disables the timeout.
- PPROT_VALUE, 3'b000, constant driven on o_pprot.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  host request valid
- o_ready  output  1  one-cycle response strobe; completes request
- i_address  input  ADDRESS_WIDTH  request byte address
- i_write  input  1  1=write, 0=read
- i_write_data  input  BUS_WIDTH  write data
- i_strobe  input  BUS_WIDTH/8  byte enables
- o_read_data  output  BUS_WIDTH  read data, valid with o_ready
- o_status  output  2  rggen_status, valid with o_ready (OKAY=2'b00, SLVERR=2'b10)
- o_psel  output  1  APB select
- o_penable  output  1  APB enable
- o_paddr  output  ADDRESS_WIDTH  APB address
- o_pprot  output  3  APB protection
- o_pwrite  output  1  APB direction
- o_pwdata  output  BUS_WIDTH  APB write data
- o_pstrb  output  BUS_WIDTH/8  APB strobes
- i_pready  input  1  APB ready
- i_prdata  input  BUS_WIDTH  APB read data
- i_pslverr  input  1  APB slave error

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0, except o_pprot=PPROT_VALUE.
- States: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE:
  - On i_valid: register address, write, write_data, strobe; go to SETUP.
  - o_paddr = i_address with its low log2(BUS_WIDTH/8) bits forced to 0.
  - Reads: o_pwdata=0, o_pstrb=0. Writes: o_pwdata=i_write_data, o_pstrb=i_strobe.
- SETUP: o_psel=1, o_penable=0; go to ACCESS next cycle unconditionally.
- ACCESS:
  - o_psel=1, o_penable=1; paddr/pwrite/pwdata/pstrb held stable.
  - On i_pready=1:
    - Capture read data = (read ? i_prdata : 0); status = i_pslverr ? SLVERR : OKAY.
    - Drop psel/penable next cycle; go to RESPONSE.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entering ACCESS and increments each ACCESS cycle with i_pready=0.
  - When the count reaches TIMEOUT_CYCLES with i_pready still 0: abort (drop psel/penable), read data 0, status SLVERR, go to RESPONSE.
  - i_pready=1 in the same cycle the limit is hit wins: normal completion.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); no wrap possible.
- RESPONSE:
  - o_ready=1 for exactly one cycle with o_read_data/o_status; go to IDLE.
  - o_read_data/o_status hold their values afterwards until the next capture.
- Latency:
  - i_valid at cycle N -> SETUP at N+1, ACCESS at N+2.
  - Zero-wait slave: o_ready at N+3.
  - Each pready wait state adds 1 cycle.
  - Minimum 4 cycles between back-to-back request acceptances.
- Host rules:
  - Host holds i_valid and request fields until o_ready.
  - Bridge samples the request only in IDLE; later changes are ignored.
  - i_valid dropped mid-transfer does not abort the transfer.
  - i_valid=1 during RESPONSE is not accepted until the following IDLE cycle.
- APB side:
  - o_psel never asserts outside SETUP/ACCESS.
  - o_penable never asserts without o_psel.
  - No psel gap is required between transfers; the RESPONSE/IDLE cycles naturally provide one.
- Reset mid-transfer: outputs drop to reset values immediately (asynchronous); no response is issued for the aborted request.

Test Plan:
- Read, zero-wait: i_valid=1, i_write=0, i_address=8'h14, slave pready=1 with prdata=32'hDEADBEEF in the first ACCESS cycle -> psel at N+1, penable at N+2, o_ready at N+3, o_read_data=32'hDEADBEEF, o_status=2'b00, o_pstrb=0.
- Write with 3 wait states: address 8'h08, wdata 32'h12345678, strobe 4'b0101 -> paddr/pwdata/pstrb stable through 4 ACCESS cycles, o_ready at N+6, o_status=OKAY, o_read_data=0.
- Slave error: read with pslverr=1 on pready -> o_status=2'b10, o_read_data=i_prdata.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles, o_ready one cycle later, o_status=2'b10, o_read_data=0. Repeat with pready=1 on the 4th ACCESS cycle -> OKAY.
- Unaligned address: i_address=8'h17, BUS_WIDTH=32 -> o_paddr=8'h14.
- Async reset: assert i_rst_n=0 during ACCESS -> psel/penable/o_ready are 0 immediately; after release, the next request completes normally in 4 cycles.
